// File: rtl/ahbl_arbiter_ctrl.sv
// Arbitration control for one AHB-Lite crossbar slave port: round-robin address-phase
// grant with per-port buffering, master-lock support and data-phase ownership tracking.
module ahbl_arbiter_ctrl #(
    parameter int N_PORTS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2*N_PORTS-1:0]   req_htrans,
    input  logic [N_PORTS-1:0]     req_hready,
    input  logic [N_PORTS-1:0]     req_hmastlock,
    input  logic                   ahbls_hready_resp,
    output logic [N_PORTS-1:0]     gnt_aph,
    output logic                   aph_from_buf,
    output logic [N_PORTS-1:0]     gnt_dph,
    output logic [N_PORTS-1:0]     buf_capture,
    output logic [N_PORTS-1:0]     buf_valid,
    output logic [N_PORTS-1:0]     ahblm_hready_resp
);

    localparam int IDX_W = $clog2(N_PORTS);
    typedef logic [IDX_W-1:0] idx_t;

    idx_t               last_gnt;
    idx_t               lock_owner;
    logic               lock_active;
    logic [N_PORTS-1:0] buf_lock;

    logic [N_PORTS-1:0] live;
    logic [N_PORTS-1:0] cand;
    logic [N_PORTS-1:0] elig;
    idx_t               winner;
    idx_t               scan_idx;
    logic               found;
    logic               grant;
    logic               win_lock;
    logic               owner_idle;

    // A port with a buffered request is stalled upstream, so its live bus is ignored.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        live = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            live[i] = req_hready[i] & req_htrans[2*i+1] & ~buf_valid[i];
        end
        cand = buf_valid | live;
        elig = cand;
        if (lock_active) begin
            elig = cand & (N_PORTS'(1) << lock_owner);
        end
    end

    // Round-robin scan starting just above the previous winner.
    always_comb begin
        winner   = last_gnt;
        scan_idx = '0;
        found    = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            scan_idx = idx_t'((int'(last_gnt) + k) % N_PORTS);
            if (!found && elig[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    assign grant        = ahbls_hready_resp & found;
    assign gnt_aph      = grant ? (N_PORTS'(1) << winner) : '0;
    assign aph_from_buf = grant & buf_valid[winner];
    assign buf_capture  = live & ~(gnt_aph & {N_PORTS{~aph_from_buf}});
    assign win_lock     = aph_from_buf ? buf_lock[winner] : req_hmastlock[winner];

    assign owner_idle = req_hready[lock_owner] & ~req_hmastlock[lock_owner]
                      & (req_htrans[{lock_owner, 1'b0} +: 2] == 2'b00);

    // The data-phase owner sees the slave's ready; everyone else is held only while buffered.
    assign ahblm_hready_resp = (gnt_dph & {N_PORTS{ahbls_hready_resp}})
                             | (~gnt_dph & ~buf_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt    <= idx_t'(N_PORTS - 1);
            lock_owner  <= '0;
            lock_active <= 1'b0;
            gnt_dph     <= '0;
            buf_valid   <= '0;
            // NOTE: buffer lock bits are reset too; they are a handful of flops and this keeps
            // lock decisions deterministic even if a stale bit were ever consulted.
            buf_lock    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            if (ahbls_hready_resp) begin
                gnt_dph <= gnt_aph;
            end
            buf_valid <= (buf_valid | buf_capture) & ~(gnt_aph & {N_PORTS{aph_from_buf}});
            buf_lock  <= (buf_lock & ~buf_capture) | (req_hmastlock & buf_capture);

            // While locked only the owner can be granted, so an unlocked grant ends the lock.
            if (grant) begin
                last_gnt <= winner;
                if (win_lock) begin
                    lock_active <= 1'b1;
                    lock_owner  <= winner;
                end else begin
                    lock_active <= 1'b0;
                end
            end else if (lock_active && owner_idle) begin
                lock_active <= 1'b0;
            end
        end
    end

endmodule
